// File: rtl/ex_hilo_muldiv_pkg.sv
// Shared constants, FSM encoding and helpers for the execute-stage HI/LO multiply/divide unit.
package ex_hilo_muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = 32;
    localparam int CNT_W  = $clog2(ITER);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] F_MFHI   = 6'b010000;
    localparam logic [5:0] F_MTHI   = 6'b010001;
    localparam logic [5:0] F_MFLO   = 6'b010010;
    localparam logic [5:0] F_MTLO   = 6'b010011;
    localparam logic [5:0] F_MULT   = 6'b011000;
    localparam logic [5:0] F_MULTU  = 6'b011001;
    localparam logic [5:0] F_DIV    = 6'b011010;
    localparam logic [5:0] F_DIVU   = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Everything the sign-fix stage needs, captured at acceptance.
    typedef struct packed {
        logic              is_div;
        logic              neg;
        logic              rneg;
        logic              div0;
        logic [DATA_W-1:0] op1;
    } op_t;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic is_signed);
        return (is_signed && x[DATA_W-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/ex_hilo_muldiv_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module ex_hilo_muldiv_iter_core
    import ex_hilo_muldiv_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                load,
    input  logic                step,
    input  logic                is_div,
    input  logic [DATA_W-1:0]   a_mag,
    input  logic [DATA_W-1:0]   b_mag,
    output logic [2*DATA_W-1:0] acc,
    output logic                cnt_last
);

    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic                div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W:0]     sum;
    logic [DATA_W+1:0]   trial;

    // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        sum    = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        trial  = {1'b0, acc_q[2*DATA_W-1:DATA_W-1]} - {2'b00, opnd_q};
        if (load) begin
            acc_d  = {{DATA_W{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd_d = is_div ? b_mag : a_mag;
            div_d  = is_div;
            cnt_d  = '0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!div_q) begin
                acc_d = {sum, acc_q[DATA_W-1:1]};
            end else if (!trial[DATA_W+1]) begin
                acc_d = {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

    assign acc      = acc_q;
    assign cnt_last = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/ex_hilo_muldiv.sv
// HI/LO multiply/divide unit: decode, IDLE/RUN/FIX control, sign fix, HI/LO registers and stall.
//   state  | meaning
//   S_IDLE | no operation in flight; MTxx/MFxx served, mult/div accepted
//   S_RUN  | one radix-2 step per cycle in the core
//   S_FIX  | apply signs to the magnitude result and write HI/LO
module ex_hilo_muldiv
    import ex_hilo_muldiv_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       Ins,
    input  logic [DATA_W-1:0] Rdata1,
    input  logic [DATA_W-1:0] Rdata2,
    output logic [DATA_W-1:0] HiLoOut,
    output logic              HiLoSel,
    output logic              Busy,
    output logic              Stall
);

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                busy_q, busy_d;
    logic [2*DATA_W-1:0] core_acc, prod;
    logic [DATA_W-1:0]   quot, rem;
    logic                cnt_last;
    logic                rtype, is_md, is_mt, is_mf, is_hilo, op_signed, load;
    logic [5:0]          funct;
    logic                unused_ins;

    assign unused_ins = ^Ins[25:6];
    assign funct      = Ins[5:0];
    assign rtype      = (Ins[31:26] == OP_RTYPE);
    assign is_md      = rtype && (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign is_mt      = rtype && (funct inside {F_MTHI, F_MTLO});
    assign is_mf      = rtype && (funct inside {F_MFHI, F_MFLO});
    assign is_hilo    = is_md || is_mt || is_mf;
    assign op_signed  = ~funct[0];
    assign load       = (state_q == S_IDLE) && is_md;

    ex_hilo_muldiv_iter_core u_core (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .step     (state_q == S_RUN),
        .is_div   (funct[1]),
        .a_mag    (mag(Rdata1, op_signed)),
        .b_mag    (mag(Rdata2, op_signed)),
        .acc      (core_acc),
        .cnt_last (cnt_last)
    );

    // Quotient sign follows the operand signs; remainder follows the dividend.
    assign prod = op_q.neg  ? -core_acc : core_acc;
    assign quot = op_q.neg  ? -core_acc[DATA_W-1:0] : core_acc[DATA_W-1:0];
    assign rem  = op_q.rneg ? -core_acc[2*DATA_W-1:DATA_W] : core_acc[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (is_md) begin
                    state_d     = S_RUN;
                    op_d.is_div = funct[1];
                    op_d.neg    = op_signed && (Rdata1[DATA_W-1] ^ Rdata2[DATA_W-1]);
                    op_d.rneg   = op_signed && Rdata1[DATA_W-1];
                    op_d.div0   = (Rdata2 == '0);
                    op_d.op1    = Rdata1;
                end else if (is_mt) begin
                    if (funct == F_MTHI) hi_d = Rdata1;
                    else                 lo_d = Rdata1;
                end
            end
            S_RUN: begin
                if (cnt_last) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!op_q.is_div) begin
                    {hi_d, lo_d} = prod;
                end else if (op_q.div0) begin
                    hi_d = op_q.op1;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        HiLoOut = '0;
        if (is_mf) HiLoOut = (funct == F_MFHI) ? hi_q : lo_q;
    end

    assign HiLoSel = is_mf;
    assign Busy    = busy_q;
    assign Stall   = busy_q && is_hilo;

endmodule
